// File: rtl/evt_decoder_level_1.sv
// evt_decoder_level_1: rebuilds a row/column event bitmap from address events and emits one frame per group release.
// A closed frame that cannot be emitted is parked in a one-deep retained slot while the FSM stalls.
package lib_arbiter_pkg;
    parameter int LVL_ROWS = 4;
    parameter int LVL_COLS = 4;
    parameter int LVL_ADD  = 2;
endpackage

module evt_decoder_level_1 #(
    parameter int Lvl_ROWS = lib_arbiter_pkg::LVL_ROWS,
    parameter int Lvl_COLS = lib_arbiter_pkg::LVL_COLS,
    parameter int Lvl_ADD  = lib_arbiter_pkg::LVL_ADD
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               evt_valid_i,
    input  logic [Lvl_ADD-1:0]                 x_add_i,
    input  logic [Lvl_ADD-1:0]                 y_add_i,
    input  logic                               grp_release_i,
    output logic                               evt_ready_o,
    output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  frame_o,
    output logic                               frame_valid_o,
    input  logic                               frame_ready_i,
    output logic [2*Lvl_ADD:0]                 evt_cnt_o,
    output logic [7:0]                         frame_cnt_o,
    output logic                               dup_err_o,
    output logic                               addr_err_o
);
    localparam int CW = 2*Lvl_ADD+1;

    typedef enum logic [1:0] {IDLE, COLLECT, STALL} state_t;

    state_t                            r_state;
    logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] r_acc, r_ret, w_hit, w_new, w_merged;
    logic [CW-1:0]                     r_cnt, r_ret_cnt, w_merged_cnt;
    logic                              w_accept, w_in_range, w_dup, w_close, w_emit;

    // One-hot of the incoming address; all-zero when the address is out of range.
    always_comb begin
        w_hit = '0;
        for (int r = 0; r < Lvl_ROWS; r++)
            for (int c = 0; c < Lvl_COLS; c++)
                w_hit[r][c] = (32'(x_add_i) == 32'(r)) && (32'(y_add_i) == 32'(c));
    end

    assign evt_ready_o  = enable_i && (r_state == COLLECT);
    assign w_accept     = evt_valid_i && evt_ready_o;
    assign w_in_range   = |w_hit;
    assign w_dup        = w_accept && |(w_hit & r_acc);
    assign w_new        = w_accept ? (w_hit & ~r_acc) : '0;
    assign w_merged     = r_acc | w_new;
    assign w_merged_cnt = r_cnt + CW'(|w_new);
    assign w_close      = evt_ready_o && grp_release_i && (w_merged_cnt != '0);
    assign w_emit       = !frame_valid_o || frame_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_ret         <= '0;
            r_ret_cnt     <= '0;
            frame_o       <= '0;
            evt_cnt_o     <= '0;
            frame_cnt_o   <= '0;
            frame_valid_o <= 1'b0;
            dup_err_o     <= 1'b0;
            addr_err_o    <= 1'b0;
        end else begin
            dup_err_o  <= w_dup;
            addr_err_o <= w_accept && !w_in_range;
            if (frame_ready_i)
                frame_valid_o <= 1'b0;
            if (!enable_i) begin
                r_state   <= IDLE;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ret     <= '0;
                r_ret_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: r_state <= COLLECT;
                    COLLECT: begin
                        if (w_close) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                            if (w_emit) begin
                                frame_o       <= w_merged;
                                evt_cnt_o     <= w_merged_cnt;
                                frame_valid_o <= 1'b1;
                                frame_cnt_o   <= frame_cnt_o + 8'd1;
                            end else begin
                                r_ret     <= w_merged;
                                r_ret_cnt <= w_merged_cnt;
                                r_state   <= STALL;
                            end
                        end else begin
                            r_acc <= w_merged;
                            r_cnt <= w_merged_cnt;
                        end
                    end
                    STALL: begin
                        // Retained frame replaces the consumed one, so valid never drops.
                        if (frame_ready_i) begin
                            frame_o       <= r_ret;
                            evt_cnt_o     <= r_ret_cnt;
                            frame_valid_o <= 1'b1;
                            frame_cnt_o   <= frame_cnt_o + 8'd1;
                            r_state       <= COLLECT;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_evt_decoder_level_1.sv
// tb_evt_decoder_level_1: vector table, hand-written corner sequences and a random run against a set-based model.
module tb_evt_decoder_level_1;
    localparam int R = 4, C = 4, A = 2;

    logic clk = 1'b0, reset_i = 1'b1, enable_i = 1'b1, evt_valid_i = 1'b0;
    logic grp_release_i = 1'b0, frame_ready_i = 1'b0;
    logic [A-1:0] x_add_i = '0, y_add_i = '0;
    logic evt_ready_o, frame_valid_o, dup_err_o, addr_err_o;
    logic [R-1:0][C-1:0] frame_o;
    logic [2*A:0] evt_cnt_o;
    logic [7:0] frame_cnt_o;
    logic s_ready, s_valid, s_dup, s_aerr;
    logic [2:0][C-1:0] s_frame;
    logic [2*A:0] s_evc;
    logic [7:0] s_fcnt;

    int n_chk = 0, n_pass = 0;

    evt_decoder_level_1 dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .evt_valid_i(evt_valid_i),
        .x_add_i(x_add_i), .y_add_i(y_add_i), .grp_release_i(grp_release_i),
        .evt_ready_o(evt_ready_o), .frame_o(frame_o), .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i), .evt_cnt_o(evt_cnt_o), .frame_cnt_o(frame_cnt_o),
        .dup_err_o(dup_err_o), .addr_err_o(addr_err_o));

    evt_decoder_level_1 #(.Lvl_ROWS(3)) dut3 (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .evt_valid_i(evt_valid_i),
        .x_add_i(x_add_i), .y_add_i(y_add_i), .grp_release_i(grp_release_i),
        .evt_ready_o(s_ready), .frame_o(s_frame), .frame_valid_o(s_valid),
        .frame_ready_i(frame_ready_i), .evt_cnt_o(s_evc), .frame_cnt_o(s_fcnt),
        .dup_err_o(s_dup), .addr_err_o(s_aerr));

    always #5 clk = ~clk;

    typedef struct {
        bit en, vld; bit [1:0] x, y; bit rel, rdy;
        bit e_rdy, e_val; int e_evc, e_fcnt; bit e_dup; bit [15:0] e_frame;
    } vec_t;
    vec_t tv[20];

    // Reference model: accumulator and retained frame are sets of flat keys x*C+y.
    int macc[int];
    int mret[int];
    bit [15:0] mframe;
    int mevc, mfcnt, mmode;
    bit mval, mdup;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input bit en, input bit v, input int x, input int y, input bit rel, input bit rdy);
        enable_i = en; evt_valid_i = v; x_add_i = A'(x); y_add_i = A'(y);
        grp_release_i = rel; frame_ready_i = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        drive(1, 0, 0, 0, 0, 0);
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit v, input int x, input int y, input bit rel, input bit rdy);
        mdup = 0;
        if (!en) begin
            mmode = 0; macc.delete(); mret.delete();
            if (rdy) mval = 0;
        end else if (mmode == 0) begin
            mmode = 1;
            if (rdy) mval = 0;
        end else if (mmode == 2) begin
            if (rdy) begin
                mframe = 0;
                foreach (mret[j]) mframe[j] = 1'b1;
                mevc = mret.size(); mfcnt = (mfcnt + 1) % 256; mret.delete(); mmode = 1;
            end
        end else begin
            if (v) begin
                if (macc.exists(x*C+y)) mdup = 1;
                else macc[x*C+y] = 1;
            end
            if (rel && macc.size() > 0) begin
                if (!mval || rdy) begin
                    mframe = 0;
                    foreach (macc[j]) mframe[j] = 1'b1;
                    mevc = macc.size(); mval = 1; mfcnt = (mfcnt + 1) % 256;
                end else begin
                    mret = macc; mmode = 2;
                end
                macc.delete();
            end else if (rdy) mval = 0;
        end
    endtask

    initial begin
        tv[0]  = '{1,0,0,0,0,0, 0,0,0,0,0,16'h0000};
        tv[1]  = '{1,1,0,1,0,0, 1,0,0,0,0,16'h0000};
        tv[2]  = '{1,1,2,3,0,0, 1,0,0,0,0,16'h0000};
        tv[3]  = '{1,0,0,0,1,1, 1,1,2,1,0,16'h0802};
        tv[4]  = '{1,1,1,1,0,1, 1,0,2,1,0,16'h0802};
        tv[5]  = '{1,1,1,1,0,0, 1,0,2,1,1,16'h0802};
        tv[6]  = '{1,1,3,0,0,0, 1,0,2,1,0,16'h0802};
        tv[7]  = '{1,0,0,0,1,0, 1,1,2,2,0,16'h1020};
        tv[8]  = '{1,0,0,0,0,1, 1,0,2,2,0,16'h1020};
        tv[9]  = '{1,1,3,3,1,0, 1,1,1,3,0,16'h8000};
        tv[10] = '{1,0,0,0,1,1, 1,0,1,3,0,16'h8000};
        tv[11] = '{1,0,0,0,1,0, 1,0,1,3,0,16'h8000};
        tv[12] = '{1,1,0,0,0,0, 1,0,1,3,0,16'h8000};
        tv[13] = '{1,0,0,0,1,0, 1,1,1,4,0,16'h0001};
        tv[14] = '{1,1,1,2,0,0, 1,1,1,4,0,16'h0001};
        tv[15] = '{1,0,0,0,1,0, 1,1,1,4,0,16'h0001};
        tv[16] = '{1,1,2,2,0,0, 0,1,1,4,0,16'h0001};
        tv[17] = '{1,0,0,0,0,1, 0,1,1,5,0,16'h0040};
        tv[18] = '{1,0,0,0,0,1, 1,0,1,5,0,16'h0040};
        tv[19] = '{1,0,0,0,1,0, 1,0,1,5,0,16'h0040};

        #12;
        chk("rst_ready", evt_ready_o, 0);
        chk("rst_valid", frame_valid_o, 0);
        chk("rst_frame", frame_o, 0);
        chk("rst_evc", evt_cnt_o, 0);
        chk("rst_fcnt", frame_cnt_o, 0);
        chk("rst_dup", dup_err_o, 0);
        chk("rst_aerr", addr_err_o, 0);
        step();
        reset_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tv[i].en, tv[i].vld, tv[i].x, tv[i].y, tv[i].rel, tv[i].rdy);
            #1;
            chk($sformatf("tv%0d_ready", i), evt_ready_o, tv[i].e_rdy);
            step();
            chk($sformatf("tv%0d_valid", i), frame_valid_o, tv[i].e_val);
            chk($sformatf("tv%0d_evc", i), evt_cnt_o, tv[i].e_evc);
            chk($sformatf("tv%0d_fcnt", i), frame_cnt_o, tv[i].e_fcnt);
            chk($sformatf("tv%0d_dup", i), dup_err_o, tv[i].e_dup);
            chk($sformatf("tv%0d_frame", i), frame_o, tv[i].e_frame);
            chk($sformatf("tv%0d_aerr", i), addr_err_o, 0);
        end

        // Asynchronous reset after two events: everything clears before the next edge.
        drive(1, 1, 0, 0, 0, 0); step();
        drive(1, 1, 1, 1, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_fcnt", frame_cnt_o, 0);
        chk("arst_frame", frame_o, 0);
        chk("arst_ready", evt_ready_o, 0);
        step();
        reset_i = 1'b0;
        step();
        drive(1, 1, 2, 0, 0, 0); step();
        drive(1, 0, 0, 0, 1, 0); step();
        chk("arst_post_valid", frame_valid_o, 1);
        chk("arst_post_frame", frame_o, 16'h0100);
        chk("arst_post_evc", evt_cnt_o, 1);
        chk("arst_post_fcnt", frame_cnt_o, 1);
        drive(1, 0, 0, 0, 0, 1); step();

        // Disable after two events drops the partial frame.
        drive(1, 1, 0, 3, 0, 0); step();
        drive(1, 1, 3, 1, 0, 0); step();
        drive(0, 1, 2, 2, 0, 0);
        #1 chk("dis_ready", evt_ready_o, 0);
        step();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 1, 1, 0, 0, 0); step();
        drive(1, 0, 0, 0, 1, 0); step();
        chk("dis_post_valid", frame_valid_o, 1);
        chk("dis_post_frame", frame_o, 16'h0010);
        chk("dis_post_evc", evt_cnt_o, 1);
        chk("dis_post_fcnt", frame_cnt_o, 2);

        // Three-row instance: row 3 is out of range and must be dropped.
        rst_pulse();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 1, 3, 0, 0, 0); step();
        chk("range_aerr", s_aerr, 1);
        chk("range_aerr_main", addr_err_o, 0);
        drive(1, 0, 0, 0, 0, 0); step();
        chk("range_aerr_pulse", s_aerr, 0);
        drive(1, 0, 0, 0, 1, 0); step();
        chk("range_drop_valid", s_valid, 0);
        chk("range_drop_fcnt", s_fcnt, 0);
        drive(1, 1, 2, 1, 1, 0); step();
        chk("range_ok_valid", s_valid, 1);
        chk("range_ok_frame", s_frame, 12'h200);
        chk("range_ok_evc", s_evc, 1);

        // 256 back-to-back frames wrap the frame counter.
        rst_pulse();
        drive(1, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 255; i++) begin
            drive(1, 1, 0, 0, 1, 1); step();
        end
        chk("wrap_255", frame_cnt_o, 255);
        drive(1, 1, 0, 0, 1, 1); step();
        chk("wrap_0", frame_cnt_o, 0);
        chk("wrap_valid", frame_valid_o, 1);

        // Random traffic against the reference model.
        rst_pulse();
        macc.delete(); mret.delete();
        mframe = 0; mevc = 0; mfcnt = 0; mmode = 0; mval = 0; mdup = 0;
        for (int i = 0; i < 1500; i++) begin
            bit en, v, rel, rdy;
            int x, y;
            en = $urandom_range(0, 15) != 0;
            v = $urandom_range(0, 1) == 1;
            x = $urandom_range(0, R-1);
            y = $urandom_range(0, C-1);
            rel = $urandom_range(0, 4) == 0;
            rdy = $urandom_range(0, 1) == 1;
            drive(en, v, x, y, rel, rdy);
            #1 chk("rnd_ready", evt_ready_o, 32'(en && mmode == 1));
            model_step(en, v, x, y, rel, rdy);
            step();
            chk("rnd_valid", frame_valid_o, 32'(mval));
            chk("rnd_frame", frame_o, 32'(mframe));
            chk("rnd_evc", evt_cnt_o, mevc);
            chk("rnd_fcnt", frame_cnt_o, mfcnt);
            chk("rnd_dup", dup_err_o, 32'(mdup));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
